// File: rtl/datamemory_pkg.sv
// Shared definitions for the datamemory_bus load/store block:
// access-size encodings, controller state type and latency bound.
package datamemory_pkg;

    localparam int unsigned MAX_READ_LATENCY = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/datamemory_array.sv
// Word-organised synchronous RAM with per-byte write enables, a registered
// read port and READ_LATENCY-1 extra output pipeline stages.
module datamemory_array
    import datamemory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WORD_AW      = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic                    re_i,
    input  logic [WORD_AW-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned NUM_WORDS = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem_q  [NUM_WORDS];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Stage 0 only loads on a read, so the tail holds steady while a response waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (re_i) begin
                pipe_q[0] <= mem_q[addr_i];
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rdata_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/datamemory_bus.sv
// Single-outstanding load/store data memory with valid/ready request and response.
// Define DATAMEMORY_ALIGN_CHECK_EN to flag misaligned/reserved-size requests via rsp_err.
module datamemory_bus
    import datamemory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(NUM_BYTES);
    localparam int unsigned WORD_AW   = ADDR_WIDTH - OFF_W;
    localparam int unsigned CNT_W     = $clog2(MAX_READ_LATENCY);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 err_q, err_d;
    logic                 load_ok_q, load_ok_d;
    logic                 uns_q, uns_d;
    logic [1:0]           size_q, size_d;
    logic [OFF_W-1:0]     off_q, off_d;

    logic [1:0]            size_eff;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic                  req_err;
    logic                  accept;
    logic [NUM_BYTES-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;
    int unsigned           ext_bits;
    logic                  ext_sign;

    // Request qualification: either flag bad alignment or silently align.
    always_comb begin
        size_eff = req_size;
        addr_eff = req_addr;
        req_err  = 1'b0;
`ifdef DATAMEMORY_ALIGN_CHECK_EN
        req_err = (req_size == SIZE_RSVD) ||
                  ((req_size == SIZE_HALF) && req_addr[0]) ||
                  ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == SIZE_RSVD) begin
            size_eff = SIZE_WORD;
        end
        if (size_eff == SIZE_HALF) begin
            addr_eff[0] = 1'b0;
        end else if (size_eff == SIZE_WORD) begin
            addr_eff[1:0] = 2'b00;
        end
`endif
    end

    assign accept = req_valid && req_ready_q;

    always_comb begin
        unique case (size_eff)
            SIZE_BYTE: wr_be = NUM_BYTES'(4'b0001);
            SIZE_HALF: wr_be = NUM_BYTES'(4'b0011);
            default:   wr_be = NUM_BYTES'(4'b1111);
        endcase
        wr_be   = wr_be << addr_eff[OFF_W-1:0];
        wr_data = req_wdata << {addr_eff[OFF_W-1:0], 3'b000};
    end

    datamemory_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WORD_AW      (WORD_AW),
        .READ_LATENCY (READ_LATENCY)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && req_we && !req_err),
        .be_i    (wr_be),
        .re_i    (accept && !req_we),
        .addr_i  (addr_eff[ADDR_WIDTH-1:OFF_W]),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        err_d       = err_q;
        load_ok_d   = load_ok_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    err_d       = req_err;
                    load_ok_d   = !req_we && !req_err;
                    uns_d       = req_unsigned;
                    size_d      = size_eff;
                    off_d       = addr_eff[OFF_W-1:0];
                    if (req_we || (READ_LATENCY == 1)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    load_ok_d   = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
            load_ok_q   <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SIZE_BYTE;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            err_q       <= err_d;
            load_ok_q   <= load_ok_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            off_q       <= off_d;
        end
    end

    // Lane extraction and extension from the stable RAM output register.
    always_comb begin
        shifted  = ram_rdata >> {off_q, 3'b000};
        ext      = shifted;
        ext_bits = 32;
        unique case (size_q)
            SIZE_BYTE: ext_bits = 8;
            SIZE_HALF: ext_bits = 16;
            default:   ext_bits = 32;
        endcase
        ext_sign = !uns_q && shifted[ext_bits-1];
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i >= ext_bits) begin
                ext[i] = ext_sign;
            end
        end
        rsp_rdata = (rsp_valid_q && load_ok_q) ? ext : '0;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/datamemory_bus.md
DATAMEMORY_BUS -- requirements
Module: datamemory_bus

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits (multiple of 8, at least 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte-address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from accepted read to rsp_valid.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous reset, active low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_addr  input  ADDR_WIDTH  byte address.
REQ-013 req_wdata  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-017 rsp_err  output  1  misaligned or reserved-size request.

Function
REQ-018 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept when req_valid and req_ready on a rising edge; request fields captured at acceptance.
REQ-020 Store accepted: byte lanes selected by req_addr[1:0] and req_size are written on that edge; other lanes unchanged; FSM goes to RESP.
REQ-021 Load accepted: READ_LATENCY=1 goes straight to RESP; otherwise WAIT for READ_LATENCY-1 cycles, counted by a down-counter, then RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 and outputs held stable until rsp_valid and rsp_ready; then the FSM goes to IDLE (no back-to-back acceptance on that edge).
REQ-023 Load data: the selected lane is shifted to bit 0, then sign- or zero-extended to DATA_WIDTH.
REQ-024 Error: half with addr[0]=1, word with addr[1:0]!=0, or size=11; no memory write; rsp_err=1, rsp_rdata=0; the latency path is unchanged.
REQ-025 A load following a store to the same address SHALL return the stored data (write completes before the next acceptance).
REQ-026 Addresses wrap modulo 2^ADDR_WIDTH; no out-of-range condition exists.

Reset
REQ-027 rst_n low SHALL force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, latency counter=0, and req_ready=1 after release.
REQ-028 Reset during WAIT or RESP SHALL discard the pending response; memory contents are not reset.
REQ-029 A store accepted on the same edge that reset asserts SHALL NOT be required to complete.

Configuration
REQ-030 Macro DATAMEMORY_ALIGN_CHECK_EN defined: alignment and reserved-size checking per REQ-024.
REQ-031 Macro DATAMEMORY_ALIGN_CHECK_EN undefined: rsp_err tied to 0; low address bits are forced to the natural alignment of req_size; size 11 is treated as word.

Structure
REQ-032 Package datamemory_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state type, and the MAX_READ_LATENCY=4 constant.
REQ-033 Storage SHALL be the sub-module datamemory_array: a synchronous RAM with per-byte write enables and a registered read, with pipeline stages added for READ_LATENCY>1.

Verification
REQ-034 Store word 0xDEADBEEF @0x010, then load word @0x010, unsigned -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Store byte 0x80 @0x013, then load byte @0x013 signed -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x010 -> 0x80ADBEEF.
REQ-036 Load half @0x011 with the check enabled -> rsp_err=1, rsp_rdata=0, no write; with the check disabled -> half @0x010 returned.
REQ-037 READ_LATENCY=3: load accepted at cycle N -> rsp_valid at N+3; rsp_ready held low for 5 cycles -> data stable and req_ready=0 throughout.
REQ-038 Assert rst_n low in WAIT -> rsp_valid never rises, req_ready=1 after release, and earlier stores remain readable.
REQ-039 Store 16 words (data=i @4i), then load all 16 -> each returns i.
